// File: rtl/fft_pkg.sv
// Shared FFT constants and the bit-reversal helper used to place samples
// in butterfly input order.
package fft_pkg;

    localparam int NPOINT  = 64;
    localparam int LOG2N   = 6;
    localparam int WORD_W  = 32;
    localparam int FRAME_W = NPOINT * WORD_W;

    // Reverse the low log2n bits of index; bits above log2n are dropped.
    function automatic int bitrev(input int index, input int log2n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < log2n) begin
                r = (r << 1) | ((index >> i) & 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_input_packer.sv
// Packs a stream of sample words into whole FFT frames using two ping-pong
// banks, optionally in bit-reversed order.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. s_ready and frame_valid depend only on registers, and
// neither ready ever waits on its paired valid.
module fft_input_packer #(
    parameter int NPOINT = fft_pkg::NPOINT,
    parameter int WORD_W = fft_pkg::WORD_W,
    parameter int BITREV = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WORD_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [NPOINT*WORD_W-1:0] frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     frame_err
);
    import fft_pkg::*;

    // Index width follows the instance NPOINT, which may differ from the package default.
    localparam int IDX_W = $clog2(NPOINT);
    localparam int FRM_W = NPOINT * WORD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOINT - 1);

    logic [FRM_W-1:0] bank [2];
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] widx;
    logic             accept;
    logic             at_end;
    logic             commit;
    logic             early_last;
    logic             consume;

    function automatic int word_pos(input int k);
        return (BITREV != 0) ? bitrev(k, IDX_W) : k;
    endfunction

    assign s_ready     = !full[wr_bank];
    assign frame_valid = full[rd_bank];
    assign frame_data  = bank[rd_bank];

    assign accept     = s_valid && s_ready;
    assign at_end     = (widx == LAST_IDX);
    assign commit     = accept && at_end;
    assign early_last = accept && s_last && !at_end;
    assign consume    = frame_valid && frame_ready;

    // Next full flags: a commit and a consume can never target the same
    // bank (one needs it empty, the other full), so both apply together.
    always_comb begin
        full_nxt = full;
        if (consume) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (commit) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Control registers: write index, bank pointers, full flags, error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            widx      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            frame_err <= 1'b0;
        end else begin
            full      <= full_nxt;
            frame_err <= (commit && !s_last) || early_last;
            if (consume) begin
                rd_bank <= !rd_bank;
            end
            if (accept) begin
                if (commit) begin
                    widx    <= '0;
                    wr_bank <= !wr_bank;
                end else if (s_last) begin
                    // Short frame: drop it and restart filling the same bank.
                    widx <= '0;
                end else begin
                    widx <= widx + IDX_W'(1);
                end
            end
        end
    end

    // Sample storage: the accepted word lands at its (possibly bit-reversed) slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank[0] <= '0;
            bank[1] <= '0;
        end else if (accept) begin
            for (int k = 0; k < NPOINT; k++) begin
                if (widx == IDX_W'(k)) begin
                    bank[wr_bank][word_pos(k)*WORD_W +: WORD_W] <= s_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_input_packer.sv
// Directed bench for fft_input_packer: frames are modelled as samples are
// sent and compared whenever the packer hands a frame downstream.
module tb_fft_input_packer;

  localparam int NP = 64;
  localparam int W  = 32;
  localparam int FW = NP * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          s_last = 1'b0;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic          frame_err;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] tb_frame = '0;
  logic [FW-1:0] snap;
  int            tb_idx = 0;
  int            exp_err = 0;
  int            err_seen = 0;
  int            frames_seen = 0;
  int            checks = 0;
  int            errors = 0;
  int            f0;

  fft_input_packer #(.NPOINT(NP), .WORD_W(W), .BITREV(1)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_err(frame_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic int ref_bitrev(input int k);
    logic [5:0] a, r;
    a = k[5:0];
    for (int i = 0; i < 6; i++) r[5-i] = a[i];
    return int'(r);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    int bad;
    bad = -1;
    for (int i = NP - 1; i >= 0; i--) if (obs[i*W +: W] !== exp[i*W +: W]) bad = i;
    checks++;
    assert (obs === exp) else begin
      errors++;
      if (bad < 0) bad = 0;
      $error("FAIL %s: word %0d observed %0h expected %0h", tag, bad, obs[bad*W +: W], exp[bad*W +: W]);
    end
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input logic [W-1:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check_val("send_timeout", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    tb_frame[ref_bitrev(tb_idx)*W +: W] = d;
    if (tb_idx == NP - 1) begin
      exp_q.push_back(tb_frame);
      if (!last) exp_err++;
      tb_idx = 0;
    end else if (last) begin
      exp_err++;
      tb_idx = 0;
    end else begin
      tb_idx++;
    end
  endtask

  task automatic send_frame(input bit rnd, input int last_at);
    for (int k = 0; k < NP; k++)
      send(rnd ? W'($urandom) : W'(k), (k == last_at));
  endtask

  task automatic drain();
    int n;
    frame_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) err_seen++;
      if (frame_valid && frame_ready) begin
        frames_seen++;
        if (exp_q.size() == 0) check_val("unexpected_frame", 64'd1, 64'd0);
        else check_frame("frame_data", frame_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    check_val("rst_s_ready", 64'(s_ready), 64'd1);
    check_val("rst_frame_valid", 64'(frame_valid), 64'd0);
    check_val("rst_frame_err", 64'(frame_err), 64'd0);
    check_frame("rst_frame_data", frame_data, '0);
    @(posedge clk);
    #1 reset = 1'b0;

    // natural fill, bit-reversed placement
    frame_ready = 1'b1;
    send_frame(1'b0, NP - 1);
    @(negedge clk);
    check_val("fill_valid", 64'(frame_valid), 64'd1);
    check_val("fill_word1", 64'(frame_data[1*W +: W]), 64'd32);
    check_val("fill_word2", 64'(frame_data[2*W +: W]), 64'd16);
    check_val("fill_word63", 64'(frame_data[63*W +: W]), 64'd63);
    @(posedge clk);
    #1;
    drain();
    repeat (2) @(negedge clk);
    check_val("fill_no_err", 64'(err_seen), 64'(exp_err));
    @(posedge clk);
    #1;

    // back-pressure with three frames
    frame_ready = 1'b0;
    send_frame(1'b1, NP - 1);
    send_frame(1'b1, NP - 1);
    @(negedge clk);
    check_val("bp_s_ready_low", 64'(s_ready), 64'd0);
    check_val("bp_valid", 64'(frame_valid), 64'd1);
    snap = frame_data;
    check_frame("bp_frame1", snap, exp_q[0]);
    repeat (5) @(negedge clk);
    check_frame("bp_stable", frame_data, snap);
    @(posedge clk);
    #1 frame_ready = 1'b1;
    @(posedge clk);
    #1 frame_ready = 1'b0;
    @(negedge clk);
    check_val("bp_s_ready_rise", 64'(s_ready), 64'd1);
    check_val("bp_valid2", 64'(frame_valid), 64'd1);
    check_frame("bp_frame2", frame_data, exp_q[0]);
    @(posedge clk);
    #1;
    send_frame(1'b1, NP - 1);
    drain();

    // early s_last on sample 10
    f0 = frames_seen;
    for (int k = 0; k <= 10; k++) send(W'($urandom), (k == 10));
    repeat (3) @(negedge clk);
    check_val("early_err", 64'(err_seen), 64'(exp_err));
    check_val("early_no_frame", 64'(frames_seen), 64'(f0));
    check_val("early_valid_low", 64'(frame_valid), 64'd0);
    @(posedge clk);
    #1;
    send_frame(1'b1, NP - 1);
    drain();
    check_val("early_next_frame", 64'(frames_seen), 64'(f0 + 1));

    // missing s_last
    f0 = frames_seen;
    send_frame(1'b1, -1);
    drain();
    repeat (2) @(negedge clk);
    check_val("nolast_err", 64'(err_seen), 64'(exp_err));
    check_val("nolast_frame", 64'(frames_seen), 64'(f0 + 1));
    @(posedge clk);
    #1;

    // consume of bank A coincides with last accept into bank B
    frame_ready = 1'b0;
    send_frame(1'b1, NP - 1);
    for (int k = 0; k < NP - 1; k++) send(W'($urandom), 1'b0);
    frame_ready = 1'b1;
    send(W'($urandom), 1'b1);
    frame_ready = 1'b0;
    @(negedge clk);
    check_val("sim_valid", 64'(frame_valid), 64'd1);
    check_val("sim_s_ready", 64'(s_ready), 64'd1);
    check_val("sim_q_size", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) check_frame("sim_frame_b", frame_data, exp_q[0]);
    @(posedge clk);
    #1;
    drain();

    // reset mid-frame after sample 30
    for (int k = 0; k <= 30; k++) send(W'($urandom), 1'b0);
    reset = 1'b1;
    #1;
    check_val("mid_rst_valid", 64'(frame_valid), 64'd0);
    check_val("mid_rst_s_ready", 64'(s_ready), 64'd1);
    check_frame("mid_rst_data", frame_data, '0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    tb_idx = 0;
    f0 = frames_seen;
    send_frame(1'b1, NP - 1);
    drain();
    check_val("post_rst_frame", 64'(frames_seen), 64'(f0 + 1));
    repeat (2) @(negedge clk);
    check_val("final_err_count", 64'(err_seen), 64'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
